// File: rtl/nrisc_mem_dump.sv
// nrisc_mem_dump: end-of-program DataMem dump for nRisc.
// On HALT (or START) the core is frozen, a window of DataMem is read
// through the debug port and streamed out on a valid/ready byte interface.
// Optional feature macro: NRISC_DUMP_CHECKSUM_EN appends a modulo-256 sum beat.
module nrisc_mem_dump #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DUMP_BASE = 0,
    parameter int unsigned DUMP_LEN  = 5,
    parameter logic [7:0]  HALT_OP   = 8'b00000000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [7:0]        INSTR,
    input  logic              INSTR_VALID,
    input  logic              START,
    input  logic              CLEAR,
    output logic              CPU_HOLD,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic [ADDR_W-1:0] DUMP_ADDR,
    output logic              DUMP_LAST,
    output logic              DUMP_DONE
);

    localparam int unsigned CNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (DUMP_LEN > 0) ? CNT_W'(DUMP_LEN - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_READ,
        S_WAIT,
        S_SEND,
`ifdef NRISC_DUMP_CHECKSUM_EN
        S_SUM,
`endif
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             trigger_c;
    logic             xfer_c;
    logic             cnt_is_last_c;

    assign trigger_c     = (INSTR_VALID && (INSTR == HALT_OP)) || START;
    assign xfer_c        = DUMP_VALID && DUMP_READY;
    assign cnt_is_last_c = (DUMP_LEN != 0) && (cnt == CNT_LAST);

`ifdef NRISC_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_n;
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, next counter and next checksum
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
`ifdef NRISC_DUMP_CHECKSUM_EN
        sum_n   = sum;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
`ifdef NRISC_DUMP_CHECKSUM_EN
                sum_n = '0;
                if (trigger_c) state_n = (DUMP_LEN == 0) ? S_SUM : S_HOLD;
`else
                if (trigger_c) state_n = (DUMP_LEN == 0) ? S_DONE : S_HOLD;
`endif
            end
            S_HOLD: state_n = S_READ;
            S_READ: state_n = S_WAIT;
            S_WAIT: state_n = S_SEND;
            S_SEND: begin
                if (xfer_c) begin
`ifdef NRISC_DUMP_CHECKSUM_EN
                    sum_n = sum + DUMP_DATA;
`endif
                    if (cnt_is_last_c) begin
`ifdef NRISC_DUMP_CHECKSUM_EN
                        state_n = S_SUM;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        state_n = S_READ;
                    end
                end
            end
`ifdef NRISC_DUMP_CHECKSUM_EN
            S_SUM: begin
                if (xfer_c) state_n = S_DONE;
            end
`endif
            S_DONE: begin
                if (CLEAR) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered outputs, counter and read-data capture
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt        <= '0;
            CPU_HOLD   <= 1'b0;
            MEM_RD     <= 1'b0;
            MEM_ADDR   <= '0;
            DUMP_VALID <= 1'b0;
            DUMP_DATA  <= '0;
            DUMP_ADDR  <= '0;
            DUMP_LAST  <= 1'b0;
            DUMP_DONE  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            CPU_HOLD  <= (state_n != S_IDLE);
            MEM_RD    <= (state_n == S_READ);
            DUMP_DONE <= (state_n == S_DONE);
            if (state_n == S_READ) begin
                MEM_ADDR <= ADDR_W'(DUMP_BASE) + ADDR_W'(cnt_n);
            end
            if (state == S_WAIT) begin
                DUMP_DATA <= MEM_RDATA;
                DUMP_ADDR <= MEM_ADDR;
            end
`ifdef NRISC_DUMP_CHECKSUM_EN
            DUMP_VALID <= (state_n == S_SEND) || (state_n == S_SUM);
            DUMP_LAST  <= (state_n == S_SUM);
            if ((state_n == S_SUM) && (state != S_SUM)) begin
                DUMP_DATA <= sum_n;
                DUMP_ADDR <= '0;
            end
`else
            DUMP_VALID <= (state_n == S_SEND);
            DUMP_LAST  <= (state_n == S_SEND) && (DUMP_LEN != 0) && (cnt_n == CNT_LAST);
`endif
        end
    end

`ifdef NRISC_DUMP_CHECKSUM_EN
    // Running modulo-256 sum of accepted data beats
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sum <= '0;
        end else begin
            sum <= sum_n;
        end
    end
`endif

endmodule

// File: tb/tb_nrisc_mem_dump.sv
// Bench for nrisc_mem_dump: three instances (base 0/len 5, base 254/len 4,
// len 0) share stimulus; each has its own DataMem read model and scoreboard.
module tb_nrisc_mem_dump;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] a;
        logic       l;
    } beat_t;

    localparam int unsigned BASES [3] = '{0, 254, 0};
    localparam int unsigned LENS  [3] = '{5, 4, 0};

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       ivalid;
    logic       start;
    logic       clear;
    logic       ready;
    logic       tog;
    logic [3:0] pat;
    int         ph;
    logic [7:0] mem [256];

    logic [2:0] hold_v;
    logic [2:0] done_v;
    logic [2:0] valid_v;

    int unsigned n_chk;
    int unsigned n_err;

    event arm_ev;
    event flush_ev;
    event chk0_ev;
    event end_ev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // READY pattern 1-0-0-1 per cycle when enabled
    always @(posedge clk) begin
        #1;
        if (tog) begin
            ready = pat[ph];
            ph    = (ph + 1) % 4;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned B = BASES[g];
        localparam int unsigned L = LENS[g];

        logic       hold, rd, valid, last, done;
        logic [7:0] maddr, ddata, daddr, rdata;
        beat_t      q [$];
        logic [7:0] aq [$];
        logic       pv, pr;
        logic [7:0] pd, pa;

        nrisc_mem_dump #(
            .ADDR_W   (8),
            .DATA_W   (8),
            .DUMP_BASE(B),
            .DUMP_LEN (L),
            .HALT_OP  (8'h00)
        ) u_dut (
            .CLK        (clk),
            .RESET_N    (rst_n),
            .INSTR      (instr),
            .INSTR_VALID(ivalid),
            .START      (start),
            .CLEAR      (clear),
            .CPU_HOLD   (hold),
            .MEM_RD     (rd),
            .MEM_ADDR   (maddr),
            .MEM_RDATA  (rdata),
            .DUMP_VALID (valid),
            .DUMP_READY (ready),
            .DUMP_DATA  (ddata),
            .DUMP_ADDR  (daddr),
            .DUMP_LAST  (last),
            .DUMP_DONE  (done)
        );

        assign hold_v[g]  = hold;
        assign done_v[g]  = done;
        assign valid_v[g] = valid;

        // DataMem debug port: data one cycle after the read strobe
        always @(posedge clk) if (rd) rdata <= mem[maddr];

        // Expected read addresses and beats for one full dump
        always @(arm_ev) begin
            logic [7:0] s;
            logic [7:0] a;
            beat_t      b;
            s = 8'h00;
            for (int i = 0; i < int'(L); i++) begin
                a   = 8'(B + 32'(i));
                s   = s + mem[a];
                b.d = mem[a];
                b.a = a;
`ifdef NRISC_DUMP_CHECKSUM_EN
                b.l = 1'b0;
`else
                b.l = (i == int'(L) - 1);
`endif
                q.push_back(b);
                aq.push_back(a);
            end
`ifdef NRISC_DUMP_CHECKSUM_EN
            b.d = s;
            b.a = 8'h00;
            b.l = 1'b1;
            q.push_back(b);
`endif
        end

        always @(flush_ev) begin
            q.delete();
            aq.delete();
            pv = 1'b0;
        end

        always @(chk0_ev) begin
            chk($sformatf("d%0d_rst_hold", g), 32'(hold), 0);
            chk($sformatf("d%0d_rst_rd", g), 32'(rd), 0);
            chk($sformatf("d%0d_rst_maddr", g), 32'(maddr), 0);
            chk($sformatf("d%0d_rst_valid", g), 32'(valid), 0);
            chk($sformatf("d%0d_rst_data", g), 32'(ddata), 0);
            chk($sformatf("d%0d_rst_daddr", g), 32'(daddr), 0);
            chk($sformatf("d%0d_rst_last", g), 32'(last), 0);
            chk($sformatf("d%0d_rst_done", g), 32'(done), 0);
        end

        always @(end_ev) begin
            chk($sformatf("d%0d_beats_left", g), 32'(q.size()), 0);
            chk($sformatf("d%0d_reads_left", g), 32'(aq.size()), 0);
        end

        // Monitor: read addresses, stall stability, accepted beats
        always @(negedge clk) begin
            if (rst_n) begin
                if (rd) begin
                    if (aq.size() == 0) chk($sformatf("d%0d_rd_unexpected", g), 0, 1);
                    else chk($sformatf("d%0d_mem_addr", g), 32'(maddr), 32'(aq.pop_front()));
                end
                if (valid && pv && !pr) begin
                    chk($sformatf("d%0d_stall_data", g), 32'(ddata), 32'(pd));
                    chk($sformatf("d%0d_stall_addr", g), 32'(daddr), 32'(pa));
                end
                if (valid && ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("d%0d_beat_unexpected", g), 0, 1);
                    end else begin
                        beat_t e;
                        e = q.pop_front();
                        chk($sformatf("d%0d_data", g), 32'(ddata), 32'(e.d));
                        chk($sformatf("d%0d_addr", g), 32'(daddr), 32'(e.a));
                        chk($sformatf("d%0d_last", g), 32'(last), 32'(e.l));
                    end
                end
                pv = valid;
                pr = ready;
                pd = ddata;
                pa = daddr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_done();
        int c;
        c = 0;
        while (done_v != 3'b111 && c < 500) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("all_done", 32'(done_v), 32'b111);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clear_done", 32'(done_v), 0);
        chk("clear_hold", 32'(hold_v), 0);
    endtask

    initial begin
        int n;
        int c;
        rst_n  = 1'b0;
        instr  = 8'h00;
        ivalid = 1'b0;
        start  = 1'b0;
        clear  = 1'b0;
        ready  = 1'b1;
        tog    = 1'b0;
        pat    = 4'b1001;
        ph     = 0;
        n_chk  = 0;
        n_err  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h05; mem[1] = 8'h08; mem[2] = 8'hFF; mem[3] = 8'h01; mem[4] = 8'h0A;

        #23;
        ->chk0_ev;
        #1;
        tick();
        rst_n = 1'b1;

        // HALT encoding without INSTR_VALID, and another opcode with it
        repeat (4) tick();
        @(negedge clk);
        chk("hold_novalid", 32'(hold_v), 0);
        ivalid = 1'b1;
        instr  = 8'h12;
        repeat (3) tick();
        @(negedge clk);
        chk("hold_other_op", 32'(hold_v), 0);
        ivalid = 1'b0;
        instr  = 8'h00;
        tick();

        // HALT and START together: one dump
        ->arm_ev;
        ivalid = 1'b1;
        start  = 1'b1;
        tick();
        ivalid = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        chk("hold_rise", 32'(hold_v), 32'b111);
`ifdef NRISC_DUMP_CHECKSUM_EN
        chk("len0_done_early", 32'(done_v), 0);
`else
        chk("len0_done_early", 32'(done_v), 32'b100);
`endif
        chk("len0_no_valid", 32'(valid_v[2]), 0);
        run_done();
        ->end_ev;
        #1;
        chk("done_hold", 32'(hold_v), 32'b111);

        // Triggers in DONE are ignored
        ivalid = 1'b1;
        start  = 1'b1;
        repeat (3) tick();
        ivalid = 1'b0;
        start  = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("done_sticky", 32'(done_v), 32'b111);
        chk("done_hold_sticky", 32'(hold_v), 32'b111);
        do_clear();

        // START with READY toggling 1-0-0-1, plus START during the dump
        tog = 1'b1;
        ->arm_ev;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_done();
        tog   = 1'b0;
        ready = 1'b1;
        ->end_ev;
        #1;
        do_clear();

        // Reset during the third beat of instance 0
        ->arm_ev;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
        n = 0;
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (valid_v[0]) begin
                if (n == 2) break;
                if (ready) n++;
            end
        end
        chk("third_beat_seen", 32'(n), 2);
        #2;
        rst_n = 1'b0;
        #1;
        ->chk0_ev;
        #1;
        ->flush_ev;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_hold", 32'(hold_v), 0);

        // Fresh HALT restarts from DUMP_BASE
        tick();
        ->arm_ev;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
        run_done();
        ->end_ev;
        #1;
        do_clear();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
